// File: rtl/io_bus_pkg.sv
// Shared field positions, FSM state encoding and open-bus value for the IO request/response stream.
package io_bus_pkg;
  localparam int IO_REQ_WR_BIT  = 32;
  localparam int IO_REQ_ADDR_HI = 31;
  localparam int IO_REQ_ADDR_LO = 16;
  localparam int IO_REQ_DATA_HI = 15;
  localparam int IO_REQ_DATA_LO = 0;
  localparam int CMD_WORD_BIT   = 33;

  localparam logic [15:0] OPEN_BUS_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } io_master_state_t;
endpackage

// File: rtl/io_bus_master.sv
// Port-IO initiator: turns CPU IN/OUT commands into io_req beats and returns read data (open bus on timeout).
// Optional IO_WORD_SPLIT_EN: word commands go out as two byte transactions (addr, addr+1).
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_s_tvalid,
  output logic        cmd_s_tready,
  input  logic [33:0] cmd_s_tdata,
  output logic        io_req_m_tvalid,
  input  logic        io_req_m_tready,
  output logic [39:0] io_req_m_tdata,
  input  logic        io_rd_s_tvalid,
  output logic        io_rd_s_tready,
  input  logic [15:0] io_rd_s_tdata,
  output logic        rsp_m_tvalid,
  input  logic        rsp_m_tready,
  output logic [15:0] rsp_m_tdata,
  output logic        timeout_pulse,
  output logic        stale_pulse
);

`ifdef IO_WORD_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  io_master_state_t state, state_nxt;

  logic        word, wr, half;
  logic [15:0] addr, wdata, cnt;
  logic [7:0]  lo_byte;
  logic        cmd_fire, req_fire, rd_hit, tmo, rd_done, more, launch_hi;
  logic [15:0] rd_val, cmd_first;
  logic [7:0]  rd_byte;

  assign cmd_s_tready   = resetn && (state == IDLE);
  assign io_rd_s_tready = 1'b1;

  assign cmd_fire  = cmd_s_tvalid && cmd_s_tready;
  assign req_fire  = io_req_m_tvalid && io_req_m_tready;
  assign rd_hit    = (state == WAIT_RD) && io_rd_s_tvalid;
  // Data beat beats the terminal count when both land in the same cycle.
  assign tmo       = (state == WAIT_RD) && !io_rd_s_tvalid && (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rd_done   = rd_hit || tmo;
  assign more      = SPLIT && word && !half;
  assign launch_hi = more && ((req_fire && wr) || rd_done);
  assign rd_val    = rd_hit ? io_rd_s_tdata : OPEN_BUS_WORD;
  assign rd_byte   = rd_val[7:0];
  assign cmd_first = (cmd_s_tdata[CMD_WORD_BIT] && !SPLIT) ?
                     cmd_s_tdata[IO_REQ_DATA_HI:IO_REQ_DATA_LO] : {8'h00, cmd_s_tdata[7:0]};

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_fire)     state_nxt = REQ;
      REQ:     if (req_fire)     state_nxt = wr ? (more ? REQ : IDLE) : WAIT_RD;
      WAIT_RD: if (rd_done)      state_nxt = more ? REQ : RSP;
      RSP:     if (rsp_m_tready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      io_req_m_tvalid <= 1'b0;
      io_req_m_tdata  <= '0;
      rsp_m_tvalid    <= 1'b0;
      rsp_m_tdata     <= '0;
      timeout_pulse   <= 1'b0;
      stale_pulse     <= 1'b0;
      word            <= 1'b0;
      wr              <= 1'b0;
      half            <= 1'b0;
      addr            <= '0;
      wdata           <= '0;
      cnt             <= '0;
      lo_byte         <= '0;
    end else begin
      io_req_m_tvalid <= (state_nxt == REQ);
      rsp_m_tvalid    <= (state_nxt == RSP);
      timeout_pulse   <= tmo;
      stale_pulse     <= io_rd_s_tvalid && (state != WAIT_RD);

      if (cmd_fire) begin
        word           <= cmd_s_tdata[CMD_WORD_BIT];
        wr             <= cmd_s_tdata[IO_REQ_WR_BIT];
        addr           <= cmd_s_tdata[IO_REQ_ADDR_HI:IO_REQ_ADDR_LO];
        wdata          <= cmd_s_tdata[IO_REQ_DATA_HI:IO_REQ_DATA_LO];
        half           <= 1'b0;
        io_req_m_tdata <= {7'd0, cmd_s_tdata[IO_REQ_WR_BIT],
                           cmd_s_tdata[IO_REQ_ADDR_HI:IO_REQ_ADDR_LO], cmd_first};
      end

      // Second half of a split word: address wraps at 16 bits.
      if (launch_hi) begin
        half           <= 1'b1;
        io_req_m_tdata <= {7'd0, wr, addr + 16'd1, 8'h00, wdata[15:8]};
      end

      if (req_fire)
        cnt <= '0;
      else if ((state == WAIT_RD) && !io_rd_s_tvalid)
        cnt <= cnt + 16'd1;

      if (rd_done) begin
        if (more)               lo_byte     <= rd_byte;
        else if (SPLIT && word) rsp_m_tdata <= {rd_byte, lo_byte};
        else if (word)          rsp_m_tdata <= rd_val;
        else                    rsp_m_tdata <= {8'h00, rd_byte};
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: table of commands with a queue scoreboard plus timing/backpressure/reset sequences.
module tb_io_bus_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_s_tvalid;
  logic        cmd_s_tready;
  logic [33:0] cmd_s_tdata;
  logic        io_req_m_tvalid;
  logic        io_req_m_tready;
  logic [39:0] io_req_m_tdata;
  logic        io_rd_s_tvalid;
  logic        io_rd_s_tready;
  logic [15:0] io_rd_s_tdata;
  logic        rsp_m_tvalid;
  logic        rsp_m_tready;
  logic [15:0] rsp_m_tdata;
  logic        timeout_pulse;
  logic        stale_pulse;

  io_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tready(cmd_s_tready), .cmd_s_tdata(cmd_s_tdata),
    .io_req_m_tvalid(io_req_m_tvalid), .io_req_m_tready(io_req_m_tready), .io_req_m_tdata(io_req_m_tdata),
    .io_rd_s_tvalid(io_rd_s_tvalid), .io_rd_s_tready(io_rd_s_tready), .io_rd_s_tdata(io_rd_s_tdata),
    .rsp_m_tvalid(rsp_m_tvalid), .rsp_m_tready(rsp_m_tready), .rsp_m_tdata(rsp_m_tdata),
    .timeout_pulse(timeout_pulse), .stale_pulse(stale_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int stale_cnt = 0;
  logic [39:0] exp_req_q[$];
  logic [15:0] exp_rsp_q[$];

  typedef struct {
    logic [33:0] cmd;
    int          nreq;
    logic [39:0] req0;
    logic [39:0] req1;
    bit          rd;
    logic [15:0] d0;
    logic [15:0] d1;
    int          dly;   // -1: nobody answers
    logic [15:0] rsp;
    int          ntmo;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mkc(input bit w, input bit wrt, input logic [15:0] a, input logic [15:0] d);
    return {w, wrt, a, d};
  endfunction

  function automatic vec_t mkv(input logic [33:0] c, input int n, input logic [39:0] r0, input logic [39:0] r1,
                               input bit rd, input logic [15:0] d0, input logic [15:0] d1, input int dly,
                               input logic [15:0] rsp, input int ntmo);
    vec_t v;
    v.cmd = c; v.nreq = n; v.req0 = r0; v.req1 = r1; v.rd = rd;
    v.d0 = d0; v.d1 = d1; v.dly = dly; v.rsp = rsp; v.ntmo = ntmo;
    return v;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (resetn) begin
      if (io_req_m_tvalid && io_req_m_tready) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected actual=%h expected=none", io_req_m_tdata);
        end else chk("req_beat", 48'(io_req_m_tdata), 48'(exp_req_q.pop_front()));
      end
      if (rsp_m_tvalid && rsp_m_tready) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=%h expected=none", rsp_m_tdata);
        end else chk("rsp_data", 48'(rsp_m_tdata), 48'(exp_rsp_q.pop_front()));
      end
      if (timeout_pulse) tmo_cnt++;
      if (stale_pulse)   stale_cnt++;
    end
  end

  task automatic send_cmd(input logic [33:0] c);
    bit ok = 1'b0;
    cmd_s_tvalid = 1'b1;
    cmd_s_tdata  = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_s_tready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL cmd_accept actual=no_ready expected=ready"); end
    @(posedge clk); #1;
    cmd_s_tvalid = 1'b0;
  endtask

  task automatic wait_req_fire(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (io_req_m_tvalid && io_req_m_tready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s_req actual=no_beat expected=beat", name); end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_req_q.size() == 0 && exp_rsp_q.size() == 0 && cmd_s_tready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_drain actual=req%0d_rsp%0d_left expected=0", name, exp_req_q.size(), exp_rsp_q.size());
      exp_req_q.delete(); exp_rsp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rd_beat(input logic [15:0] d);
    io_rd_s_tvalid = 1'b1;
    io_rd_s_tdata  = d;
    @(posedge clk); #1;
    io_rd_s_tvalid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_req_q.push_back(v.req0);
    if (v.nreq == 2) exp_req_q.push_back(v.req1);
    if (v.rd) exp_rsp_q.push_back(v.rsp);
    send_cmd(v.cmd);
    if (v.rd) begin
      for (int h = 0; h < v.nreq; h++) begin
        wait_req_fire(name);
        @(posedge clk); #1;
        if (v.dly >= 0) begin
          repeat (v.dly) @(posedge clk);
          #1;
          rd_beat(h == 0 ? v.d0 : v.d1);
        end
      end
    end
    wait_drain(name);
  endtask

  initial begin
    int exp_tmo = 0;
    int n;
    int s0;

    // Commands: {word, write, addr, data}
    vecs[0] = mkv(mkc(0, 1, 16'h0043, 16'h0034), 1, 40'h01_0043_0034, '0, 0, '0, '0, 0, '0, 0);
    vecs[1] = mkv(mkc(0, 1, 16'h0080, 16'hAB12), 1, 40'h01_0080_0012, '0, 0, '0, '0, 0, '0, 0);
    vecs[2] = mkv(mkc(0, 0, 16'h0040, 16'h0000), 1, 40'h00_0040_0000, '0, 1, 16'h1234, '0, 5, 16'h0034, 0);
    vecs[3] = mkv(mkc(0, 0, 16'h0050, 16'h0000), 1, 40'h00_0050_0000, '0, 1, 16'h9977, '0, TMO-1, 16'h0077, 0);
    vecs[4] = mkv(mkc(0, 0, 16'h0051, 16'h0000), 1, 40'h00_0051_0000, '0, 1, 16'h33A5, '0, TMO-2, 16'h00A5, 0);
    vecs[5] = mkv(mkc(0, 0, 16'h0300, 16'h0000), 1, 40'h00_0300_0000, '0, 1, '0, '0, -1, 16'h00FF, 1);
`ifdef IO_WORD_SPLIT_EN
    vecs[6] = mkv(mkc(1, 1, 16'h0060, 16'hBEEF), 2, 40'h01_0060_00EF, 40'h01_0061_00BE, 0, '0, '0, 0, '0, 0);
    vecs[7] = mkv(mkc(1, 1, 16'hFFFF, 16'hBEEF), 2, 40'h01_FFFF_00EF, 40'h01_0000_00BE, 0, '0, '0, 0, '0, 0);
    vecs[8] = mkv(mkc(1, 0, 16'h0040, 16'h0000), 2, 40'h00_0040_0000, 40'h00_0041_0000, 1,
                  16'h0011, 16'h0022, 2, 16'h2211, 0);
    vecs[9] = mkv(mkc(1, 0, 16'h0310, 16'h0000), 2, 40'h00_0310_0000, 40'h00_0311_0000, 1,
                  '0, '0, -1, 16'hFFFF, 2);
`else
    vecs[6] = mkv(mkc(1, 1, 16'h0060, 16'hBEEF), 1, 40'h01_0060_BEEF, '0, 0, '0, '0, 0, '0, 0);
    vecs[7] = mkv(mkc(1, 1, 16'hFFFF, 16'hBEEF), 1, 40'h01_FFFF_BEEF, '0, 0, '0, '0, 0, '0, 0);
    vecs[8] = mkv(mkc(1, 0, 16'h0040, 16'h0000), 1, 40'h00_0040_0000, '0, 1, 16'hCAFE, '0, 2, 16'hCAFE, 0);
    vecs[9] = mkv(mkc(1, 0, 16'h0310, 16'h0000), 1, 40'h00_0310_0000, '0, 1, '0, '0, -1, 16'hFFFF, 1);
`endif

    resetn = 1'b0; cmd_s_tvalid = 1'b0; cmd_s_tdata = '0;
    io_req_m_tready = 1'b1; io_rd_s_tvalid = 1'b0; io_rd_s_tdata = '0; rsp_m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 48'({cmd_s_tready, io_req_m_tvalid, rsp_m_tvalid, timeout_pulse, stale_pulse}), 48'(0));
    chk("reset_req_data", 48'(io_req_m_tdata), 48'(0));
    chk("reset_rsp_data", 48'(rsp_m_tdata), 48'(0));
    chk("rd_tready", 48'(io_rd_s_tready), 48'(1));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 48'(cmd_s_tready), 48'(1));
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      exp_tmo += vecs[i].ntmo;
    end

    // Write latency and 2-cycle turnaround.
    exp_req_q.push_back(40'h01_0043_0034);
    cmd_s_tvalid = 1'b1; cmd_s_tdata = mkc(0, 1, 16'h0043, 16'h0034);
    @(negedge clk);
    chk("wr_ready", 48'(cmd_s_tready), 48'(1));
    @(posedge clk); #1;
    cmd_s_tvalid = 1'b0;
    @(negedge clk);
    chk("wr_req_n1", 48'({io_req_m_tvalid, io_req_m_tdata}), {7'd0, 1'b1, 40'h01_0043_0034});
    @(negedge clk);
    chk("wr_back_idle", 48'({io_req_m_tvalid, cmd_s_tready}), 48'(1));
    wait_drain("wr_lat");

    // Read response rises the cycle after the data beat.
    exp_req_q.push_back(40'h00_0040_0000);
    exp_rsp_q.push_back(16'h0034);
    send_cmd(mkc(0, 0, 16'h0040, 16'h0000));
    wait_req_fire("rd_lat");
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    io_rd_s_tvalid = 1'b1; io_rd_s_tdata = 16'h1234;
    @(negedge clk);
    chk("rsp_not_early", 48'(rsp_m_tvalid), 48'(0));
    @(posedge clk); #1;
    io_rd_s_tvalid = 1'b0;
    @(negedge clk);
    chk("rsp_after_beat", 48'({rsp_m_tvalid, rsp_m_tdata}), {31'd0, 1'b1, 16'h0034});
    wait_drain("rd_lat");

    // Timeout after TMO cycles in WAIT_RD, late beat is stale, next read is clean.
    exp_req_q.push_back(40'h00_0300_0000);
    exp_rsp_q.push_back(16'h00FF);
    send_cmd(mkc(0, 0, 16'h0300, 16'h0000));
    wait_req_fire("tmo");
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_pulse) break;
      n++;
    end
    chk("timeout_cycles", 48'(n), 48'(TMO));
    exp_tmo++;
    wait_drain("tmo");
    s0 = stale_cnt;
    rd_beat(16'hDEAD);
    @(negedge clk); @(negedge clk);
    chk("stale_late_beat", 48'(stale_cnt), 48'(s0 + 1));
    @(posedge clk); #1;
    run_vec(mkv(mkc(0, 0, 16'h0301, 16'h0000), 1, 40'h00_0301_0000, '0, 1, 16'h995A, '0, 3, 16'h005A, 0),
            "after_stale");

    // io_req backpressure for 10 cycles.
    io_req_m_tready = 1'b0;
    exp_req_q.push_back(40'h01_0022_0055);
    send_cmd(mkc(0, 1, 16'h0022, 16'h1155));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("req_hold", 48'({io_req_m_tvalid, io_req_m_tdata}), {7'd0, 1'b1, 40'h01_0022_0055});
    end
    @(posedge clk); #1;
    io_req_m_tready = 1'b1;
    wait_drain("req_bp");

    // rsp backpressure for 5 cycles.
    rsp_m_tready = 1'b0;
    exp_req_q.push_back(40'h00_0044_0000);
    exp_rsp_q.push_back(16'h00C3);
    send_cmd(mkc(0, 0, 16'h0044, 16'h0000));
    wait_req_fire("rsp_bp");
    @(posedge clk); #1;
    rd_beat(16'h77C3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rsp_hold", 48'({rsp_m_tvalid, rsp_m_tdata}), {31'd0, 1'b1, 16'h00C3});
    end
    @(posedge clk); #1;
    rsp_m_tready = 1'b1;
    wait_drain("rsp_bp");

    // Reset while waiting for read data; the late answer must be drained as stale.
    exp_req_q.push_back(40'h00_0045_0000);
    send_cmd(mkc(0, 0, 16'h0045, 16'h0000));
    wait_req_fire("mid_rst");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("tready_in_reset", 48'(cmd_s_tready), 48'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("valids_after_reset", 48'({io_req_m_tvalid, rsp_m_tvalid, timeout_pulse, stale_pulse}), 48'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 48'(cmd_s_tready), 48'(1));
    @(posedge clk); #1;
    s0 = stale_cnt;
    rd_beat(16'h0BAD);
    @(negedge clk); @(negedge clk);
    chk("stale_after_reset", 48'(stale_cnt), 48'(s0 + 1));
    @(posedge clk); #1;
    run_vec(mkv(mkc(0, 0, 16'h0046, 16'h0000), 1, 40'h00_0046_0000, '0, 1, 16'h1142, '0, 1, 16'h0042, 0),
            "after_reset");

    chk("timeout_total", 48'(tmo_cnt), 48'(exp_tmo));
    chk("queues_empty", 48'(exp_req_q.size() + exp_rsp_q.size()), 48'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator side of the SoC IO request/response stream that the IO peripherals (PIT, PIC, etc.) respond to.
- Accepts port-IO commands (IN/OUT, byte or word) from the CPU core and issues them as io_req beats.
- For reads, waits for the io_rd beat and returns the result to the core.
- Returns open-bus data on timeout when no peripheral answers.

Parameters:
- TIMEOUT_CYCLES, 256: cycles to wait for read data before returning open-bus value; legal range 2..65535.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- cmd_s_tvalid  in  1  CPU command valid
- cmd_s_tready  out  1  CPU command ready
- cmd_s_tdata  in  34  bit33 = word (1) / byte (0); bit32 = write (1) / read (0); [31:16] port address; [15:0] write data
- io_req_m_tvalid  out  1  IO request valid
- io_req_m_tready  in  1  IO request ready
- io_req_m_tdata  out  40  [39:33] zero; bit32 write; [31:16] address; [15:0] data
- io_rd_s_tvalid  in  1  read data valid
- io_rd_s_tready  out  1  read data ready, constant 1
- io_rd_s_tdata  in  16  read data
- rsp_m_tvalid  out  1  CPU read result valid
- rsp_m_tready  in  1  CPU read result ready
- rsp_m_tdata  out  16  CPU read result
- timeout_pulse  out  1  one-cycle pulse when a read times out
- stale_pulse  out  1  one-cycle pulse when an io_rd beat arrives outside WAIT_RD

Behaviour:
- Clock and reset: single clock clk; resetn is synchronous, active-low.
- Reset values: state IDLE; cmd_s_tready 0 during reset, 1 after; io_req_m_tvalid, rsp_m_tvalid, timeout_pulse and stale_pulse all 0; io_req_m_tdata and rsp_m_tdata 0.
- States: IDLE, REQ, WAIT_RD, RSP.
- cmd_s_tready = 1 only in IDLE.
- IDLE: on command accept in cycle N, latch the command. io_req_m_tvalid is registered high in cycle N+1 (state REQ).
- REQ: hold tvalid and tdata stable until io_req_m_tready.
  - Accepted write with no further beat -> IDLE. No response is produced for writes.
  - Accepted read -> WAIT_RD; clear the timeout counter.
- WAIT_RD:
  - Counter increments each cycle without io_rd_s_tvalid.
  - A beat received -> store data.
  - Counter reaching TIMEOUT_CYCLES-1 with no beat -> store 0xFFFF and pulse timeout_pulse.
  - If a beat and the terminal count occur in the same cycle, the data wins and there is no timeout pulse.
  - After the last beat -> RSP. rsp_m_tvalid rises the cycle after the beat is received.
- RSP: hold rsp_m_tvalid until rsp_m_tready, then -> IDLE.
- Read result formatting:
  - Byte read: rsp = {8'h00, data[7:0]}; a timed-out byte read gives 0x00FF.
  - Word read (non-split): rsp = 16-bit data; a timed-out word read gives 0xFFFF.
- io_rd_s_tready is constant 1. Beats outside WAIT_RD, e.g. a late answer after timeout, are discarded and pulse stale_pulse. They never corrupt a later read.
- Byte writes: io_req data = {8'h00, data[7:0]}.
- Reset mid-transaction: immediately return to IDLE and drop all valids. Any in-flight response is later drained as stale.
- Back-to-back throughput: one command per 2 cycles minimum for writes (IDLE -> REQ -> IDLE).

Optional Feature:
- Macro: IO_WORD_SPLIT_EN.
- Defined: word commands are split into two byte transactions, since the peripherals are 8-bit.
  - Low byte goes to addr, high byte to addr+1 (16-bit wrap: 0xFFFF+1 = 0x0000).
  - Writes send data[7:0] then data[15:8].
  - Reads assemble {second[7:0], first[7:0]}; each half has its own timeout, and a timed-out half contributes 0xFF.
  - Sequence: REQ -> WAIT_RD -> REQ (second half) -> WAIT_RD -> RSP; writes skip WAIT_RD.
  - An internal half flag selects the phase; the second request's tvalid rises the cycle after the first completes.
- Undefined: a word command is issued as a single 16-bit beat.

Decomposition:
- Package io_bus_pkg holds:
  - field position constants IO_REQ_WR_BIT = 32, IO_REQ_ADDR_HI/LO = 31/16, IO_REQ_DATA_HI/LO = 15/0, CMD_WORD_BIT = 33;
  - state enum io_master_state_t;
  - OPEN_BUS_WORD = 16'hFFFF.
- No sub-module: the timeout counter is inline.

Test Plan:
- Byte write to 0x0043 data 0x0034, io_req_m_tready = 1 -> one io_req beat with tdata = 0x01_0043_0034 in cycle N+1; no rsp.
- Byte read from 0x0040, responder returns 0x1234 after 5 cycles -> rsp_m_tdata = 0x0034 one cycle after the io_rd beat.
- Read from 0x0300 with no responder, TIMEOUT_CYCLES = 16 -> timeout_pulse after 16 cycles in WAIT_RD; rsp = 0x00FF; a later io_rd beat pulses stale_pulse and the next read returns correct data.
- With IO_WORD_SPLIT_EN, word write 0xFFFF data 0xBEEF -> beats (0xFFFF, 0x00EF) then (0x0000, 0x00BE).
- With IO_WORD_SPLIT_EN, word read 0x0040, halves return 0x0011 and 0x0022 -> rsp = 0x2211.
- io_req_m_tready held low 10 cycles, rsp_m_tready low 5 cycles, and resetn asserted mid-WAIT_RD -> tdata stable under backpressure; after reset all valids are 0 and state is IDLE.
